// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Shared iterative multiply/divide engine that produces the HI/LO results of the
// multicycle CPU. One engine handles MULT, MULTU, DIV and DIVU. Signed operations
// run on operand magnitudes and the signs are restored in a final FIX cycle.
// Multiply uses shift-add with one multiplier bit per cycle. Divide is restoring,
// with one quotient bit per cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     request; sampled only in IDLE or DONE
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b      multiplicand/dividend and multiplier/divisor (sampled with start)
//   hi, lo    product upper/lower half, or remainder/quotient (registered, held)
//   ready     one-cycle pulse in DONE: hi/lo/div_zero valid
//   busy      high while an operation is in progress (MUL, DIV, FIX)
//   div_zero  set with ready when a divide had b==0; cleared by the next start
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, a multiply runs only as many iterations
//                        as |b| has significant bits (at least one). Divide
//                        timing does not change.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ready,
    output logic             busy,
    output logic             div_zero
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W2-1:0]    r_mcand;     // MUL: shifted multiplicand; DIV: divisor in low half
    logic [W2-1:0]    r_acc;       // MUL: product; DIV: partial remainder in low half
    logic [WIDTH-1:0] r_mplr;      // MUL: remaining multiplier; DIV: dividend -> quotient
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;     // negate product / quotient in FIX
    logic             r_neg_r;     // negate remainder in FIX (dividend sign)
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;
    logic             r_busy;
    logic             r_div_zero;

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [W2-1:0] f_neg_2w(input logic [W2-1:0] v,
                                               input logic          neg);
        return neg ? ({W2{1'b0}} - v) : v;
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    // Position of the highest set bit plus one, never less than one.
    function automatic logic [CNT_W-1:0] f_mul_iters(input logic [WIDTH-1:0] m);
        logic [CNT_W-1:0] k;
        k = CNT_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) k = CNT_W'(i + 1);
        end
        return k;
    endfunction
`endif

    logic             w_signed;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [CNT_W-1:0] w_iters;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [W2-1:0]    w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_signed = ~op[0];
    assign w_b_zero = (b == {WIDTH{1'b0}});
    assign w_mag_a  = f_neg_w(a, w_signed & a[WIDTH-1]);
    assign w_mag_b  = f_neg_w(b, w_signed & b[WIDTH-1]);

`ifdef MULDIV_EARLY_OUT_EN
    // Bits of the multiplier above its top set bit add nothing, so the
    // left-shifting multiplicand lets the loop stop early with a full product.
    assign w_iters = op[1] ? CNT_W'(WIDTH) : f_mul_iters(w_mag_b);
`else
    assign w_iters = CNT_W'(WIDTH);
`endif

    // Restoring divide step. The shifted remainder needs one extra bit; when
    // it is >= divisor the true difference is below 2^WIDTH, so the low WIDTH
    // bits of the modular subtraction are exact.
    assign w_rem_sh  = {r_acc[WIDTH-1:0], r_mplr[WIDTH-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_mcand[WIDTH-1:0]});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_mcand[WIDTH-1:0];

    // Sign restoration. Most-negative / -1 falls out naturally: the quotient
    // magnitude 2^(WIDTH-1) negates to itself and the remainder is zero.
    assign w_prod = f_neg_2w(r_acc, r_neg_q);
    assign w_quot = f_neg_w(r_mplr, r_neg_q);
    assign w_rem  = f_neg_w(r_acc[WIDTH-1:0], r_neg_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplr     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_div   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_is_div   <= op[1];
                        r_neg_q    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r    <= w_signed & a[WIDTH-1];
                        r_acc      <= '0;
                        r_cnt      <= w_iters;
                        r_div_zero <= op[1] & w_b_zero;
                        if (op[1]) begin
                            r_mcand <= {{WIDTH{1'b0}}, w_mag_b};
                            r_mplr  <= w_mag_a;
                        end else begin
                            r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
                            r_mplr  <= w_mag_b;
                        end
                        // Divide by zero completes at once and leaves hi/lo untouched.
                        if (op[1] & w_b_zero) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= op[1] ? S_DIV : S_MUL;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                S_MUL: begin
                    if (r_mplr[0]) r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) r_state <= S_FIX;
                end

                S_DIV: begin
                    r_acc  <= {{WIDTH{1'b0}}, (w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0])};
                    r_mplr <= {r_mplr[WIDTH-2:0], w_rem_ge};
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) r_state <= S_FIX;
                end

                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[W2-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_state <= S_DONE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign ready    = r_ready;
    assign busy     = r_busy;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// Testbench for muldiv_unit (WIDTH=32). A behavioural model computes each
// result with plain 64-bit arithmetic and tracks when ready/busy must occur;
// a compare process checks every output on every falling edge. Directed cases
// pin the model and the DUT against hand-computed values, then random traffic
// runs against the model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M7 = 5;     // |b|=7 -> 3 iterations + 2
`else
    localparam int LAT_M7 = 34;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ready;
    logic         busy;
    logic         div_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .ready    (ready),
        .busy     (busy),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 0) return 64'h0;
                q = sx / sy;   // truncates toward zero; remainder takes dividend sign
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return 64'h0;
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int m_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int k;
`endif
        if (o[1]) return (y == 0) ? 1 : W + 2;
`ifdef MULDIV_EARLY_OUT_EN
        m = (!o[0] && y[31]) ? -y : y;
        k = 1;
        for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
        return k + 2;
`else
        return W + 2;
`endif
    endfunction

    logic        m_busy  = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_dz    = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic        m_pend  = 1'b0;
    int          m_done  = 0;
    logic [63:0] m_res   = '0;

    always @(posedge clk or negedge reset) begin
        logic acc;
        if (!reset) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_dz    = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
            m_pend  = 1'b0;
        end else begin
            cyc = cyc + 1;
            acc = start && !m_busy;
            m_ready = 1'b0;
            if (m_pend && cyc == m_done) begin
                m_ready = 1'b1;
                m_busy  = 1'b0;
                m_pend  = 1'b0;
                m_hi    = m_res[63:32];
                m_lo    = m_res[31:0];
            end
            if (acc) begin
                m_dz = op[1] && (b == 0);
                if (m_dz) begin
                    m_ready = 1'b1;
                    m_busy  = 1'b0;
                end else begin
                    m_res  = m_result(op, a, b);
                    m_done = (cyc - 1) + m_lat(op, b);
                    m_pend = 1'b1;
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",     64'(busy),     64'(m_busy));
        chk("ready",    64'(ready),    64'(m_ready));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("hi",       64'(hi),       64'(m_hi));
        chk("lo",       64'(lo),       64'(m_lo));
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
        op = o; a = x; b = y; start = 1'b1;
        n = cyc;
        step;
        start = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output int rc);
        rc = -1;
        for (int i = 0; i < bound; i++) begin
            if (ready) begin
                rc = cyc;
                return;
            end
            step;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: no ready within %0d cycles", bound);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rc, nr;
        logic [31:0] cap_hi, cap_lo;

        #2 reset = 1'b0;
        step;
        step;
        chk("rst_busy",  64'(busy),     64'h0);
        chk("rst_ready", 64'(ready),    64'h0);
        chk("rst_hi",    64'(hi),       64'h0);
        chk("rst_lo",    64'(lo),       64'h0);
        chk("rst_dz",    64'(div_zero), 64'h0);
        reset = 1'b1;
        step;

        // Model pinned against hand-computed values.
        chk("model_mult",  m_result(2'b00, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_multu", m_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_div",   m_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_ovf",   m_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        // Signed multiply with latency.
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, n);
        wait_ready(100, rc);
        chk("mult_lat", 64'(rc - n), 64'(LAT_M7));
        chk("mult_hi",  64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo",  64'(lo), 64'hFFFF_FFEB);

        // Unsigned multiply, issued in the DONE cycle.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        wait_ready(100, rc);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        // Signed divide then back-to-back unsigned divide.
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, n);
        wait_ready(100, rc);
        chk("div_lat", 64'(rc - n), 64'd34);
        chk("div_lo",  64'(lo), 64'hFFFF_FFFD);
        chk("div_hi",  64'(hi), 64'hFFFF_FFFF);
        issue(2'b11, 32'd7, 32'd2, n);
        wait_ready(100, rc);
        chk("divu_lat", 64'(rc - n), 64'd34);
        chk("divu_lo",  64'(lo), 64'd3);
        chk("divu_hi",  64'(hi), 64'd1);
        chk("divu_dz",  64'(div_zero), 64'h0);

        // Divide by zero keeps hi/lo; the next start clears div_zero.
        issue(2'b01, 32'h1234_5678, 32'h10, n);
        wait_ready(100, rc);
        chk("pre_hi", 64'(hi), 64'h1);
        chk("pre_lo", 64'(lo), 64'h2345_6780);
        issue(2'b10, 32'd99, 32'd0, n);
        wait_ready(100, rc);
        chk("dz_lat",  64'(rc - n), 64'd1);
        chk("dz_flag", 64'(div_zero), 64'h1);
        chk("dz_hi",   64'(hi), 64'h1);
        chk("dz_lo",   64'(lo), 64'h2345_6780);
        step;
        chk("dz_held", 64'(div_zero), 64'h1);
        issue(2'b00, 32'd3, 32'd3, n);
        chk("dz_clear", 64'(div_zero), 64'h0);
        wait_ready(100, rc);
        chk("mul9_lo", 64'(lo), 64'd9);

        // Most-negative / -1.
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
        wait_ready(100, rc);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);
        chk("ovf_dz", 64'(div_zero), 64'h0);

        // Reset in the middle of an operation.
        issue(2'b00, 32'd5, 32'h4000_0000, n);
        repeat (9) step;
        reset = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),  64'h0);
        chk("abort_ready", 64'(ready), 64'h0);
        chk("abort_hi",    64'(hi),    64'h0);
        chk("abort_lo",    64'(lo),    64'h0);
        step;
        step;
        reset = 1'b1;
        nr = 0;
        for (int i = 0; i < 60; i++) begin
            step;
            if (ready) nr++;
        end
        chk("abort_no_ready", 64'(nr), 64'd0);

        // A start while busy is ignored.
        issue(2'b01, 32'd100, 32'h8000_0001, n);
        repeat (4) step;
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
        step;
        start = 1'b0;
        nr = 0;
        cap_hi = '0;
        cap_lo = '0;
        for (int i = 0; i < 60; i++) begin
            if (ready) begin
                nr++;
                cap_hi = hi;
                cap_lo = lo;
            end
            step;
        end
        chk("ign_count", 64'(nr),     64'd1);
        chk("ign_hi",    64'(cap_hi), 64'h32);
        chk("ign_lo",    64'(cap_lo), 64'h64);

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            step;
        end
        start = 1'b0;
        repeat (40) step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
